instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the microsequencer. Owns the program counter and instruction register, and fetches instruction and immediate words from memory over a req/ack handshake.
- Presents a stable opcode to the sequencer's opcode input.
- Fetch commands come from sequencer control bits; completion is reported back via a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 16, memory word / IR / immediate width
- ADDR_WIDTH, 16, PC and memory address width
- OPCODE_WIDTH, 7, opcode field width (IR top bits)
- RESET_PC, 0, PC value after reset

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_ir  in  1  command: fetch instruction word at PC into IR
- fetch_imm  in  1  command: fetch word at PC into IMM
- pc_load  in  1  load PC from pc_in
- pc_in  in  ADDR_WIDTH  new PC value
- mem_req  out  1  memory read request, registered
- mem_addr  out  ADDR_WIDTH  read address, registered
- mem_ack  in  1  memory read data valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- pc  out  ADDR_WIDTH  current PC
- ir  out  DATA_WIDTH  instruction register
- opcode  out  OPCODE_WIDTH  ir[DATA_WIDTH-1 -: OPCODE_WIDTH]
- imm  out  DATA_WIDTH  immediate register
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse, fetch completed

Behaviour:
- Reset (async, any state, mid-fetch included):
  - state=IDLE, pc=RESET_PC, ir=0, imm=0
  - mem_req=0, mem_addr=0, busy=0, done=0
  - A mem_ack arriving after reset is ignored.
- States: IDLE, RD_IR, RD_IMM.
- IDLE:
  - fetch_ir=1 → RD_IR next cycle; mem_req=1, mem_addr=pc, busy=1.
  - Else fetch_imm=1 → RD_IMM, same outputs.
  - fetch_ir and fetch_imm both high: fetch_ir wins; fetch_imm is dropped, not queued.
  - pc_load=1 with a fetch command in the same cycle: pc_load is applied first, so the fetch uses pc_in as the address.
- RD_IR / RD_IMM:
  - Hold mem_req=1 and mem_addr constant until mem_ack.
  - On the mem_ack cycle: capture mem_rdata into ir (RD_IR) or imm (RD_IMM); pc<=pc+1 modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
  - Next cycle: mem_req=0, busy=0, done=1, state=IDLE.
  - Minimum latency: command at cycle N, ack at N+1, done at N+2.
- Commands and pc_load while busy are ignored; no effect on pc, ir or imm.
- A mem_ack while IDLE is ignored.
- done is high for exactly one cycle per completed fetch. A new command may be accepted in the same cycle done is high, since the state is IDLE then.
- opcode is combinational from registered ir. It is stable between IR fetches and unaffected by IMM fetches.
- mem_rdata is sampled only in the mem_ack cycle.

Decomposition:
- Shared package constants: state encodings (IDLE=0, RD_IR=1, RD_IMM=2) and the opcode field position.
- Register field slicing helpers stay alongside the existing decode constants.
- One sub-module: pc_counter. Holds the loadable, incrementing, wrapping PC with async reset to RESET_PC.
- The FSM and the IR/IMM registers stay in the top.

Test Plan:
- Reset, then fetch_ir; memory returns 0xA5C3 after 1 cycle → mem_addr=0x0000, ir=0xA5C3, opcode=0x52, pc=0x0001, done at cycle +2.
- pc_load pc_in=0x1234 with fetch_ir in the same cycle; ack after 3 wait cycles with 0x0007 → mem_addr=0x1234 held for 4 cycles, ir=0x0007, pc=0x1235.
- fetch_ir then fetch_imm; data 0x8001 then 0xBEEF → ir=0x8001, imm=0xBEEF, opcode stays 0x40 through the IMM fetch, pc advances by 2.
- pc=0xFFFF, fetch_imm, ack with 0x0042 → imm=0x0042, pc=0x0000. Same run: fetch_ir and fetch_imm together → only ir updates.
- During RD_IR: pulse fetch_imm, pc_load (pc_in=0x5555) and a stray extra command → all ignored; pc increments only from the original address.
- Assert reset while mem_req=1, then deliver mem_ack → ir and pc remain at reset values, busy=0, done never pulses.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and types for the instruction fetch unit
package instr_fetch_unit_pkg;

   // Default word widths; the opcode field is the top OPCODE_WIDTH bits of the IR.
   localparam int DEFAULT_DATA_WIDTH   = 16;
   localparam int DEFAULT_ADDR_WIDTH   = 16;
   localparam int DEFAULT_OPCODE_WIDTH = 7;

   // Fetch FSM state encoding.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_IR  = 2'd1,
      ST_RD_IMM = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// rtl/instr_fetch_unit_pc_counter.sv - loadable, incrementing, wrapping program counter
module instr_fetch_unit_pc_counter #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_value,
   input  logic                  incr,
   output logic [ADDR_WIDTH-1:0] pc
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Next PC: load has priority; increment wraps naturally at 2^ADDR_WIDTH.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_value;
      end else if (incr) begin
         pc_d = pc_q + ADDR_WIDTH'(1);
      end
   end

   // PC register with asynchronous reset to RESET_PC.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/IR/IMM owner fetching words over a req/ack memory port
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int                    OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fetch_ir,
   input  logic                    fetch_imm,
   input  logic                    pc_load,
   input  logic [ADDR_WIDTH-1:0]   pc_in,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic [DATA_WIDTH-1:0]   ir,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0]   imm,
   output logic                    busy,
   output logic                    done
);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  done_q, done_d;
   logic                  pc_load_en;
   logic                  pc_incr;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   // A same-cycle pc_load takes effect before the fetch, so the fetch address follows pc_in.
   assign fetch_addr = pc_load ? pc_in : pc;

   instr_fetch_unit_pc_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (pc_load_en),
      .load_value (pc_in),
      .incr       (pc_incr),
      .pc         (pc)
   );

   // Fetch FSM next-state and register updates; commands are only honoured in IDLE.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      imm_d      = imm_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      done_d     = 1'b0;
      pc_load_en = 1'b0;
      pc_incr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pc_load_en = pc_load;
            if (fetch_ir) begin
               state_d    = ST_RD_IR;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr;
            end else if (fetch_imm) begin
               state_d    = ST_RD_IMM;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr;
            end
         end
         ST_RD_IR, ST_RD_IMM: begin
            if (mem_ack) begin
               if (state_q == ST_RD_IR) begin
                  ir_d = mem_rdata;
               end else begin
                  imm_d = mem_rdata;
               end
               pc_incr   = 1'b1;
               mem_req_d = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any outstanding fetch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ir_q       <= '0;
         imm_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         imm_q      <= imm_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         done_q     <= done_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign ir       = ir_q;
   assign imm      = imm_q;
   assign opcode   = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule
